// File: rtl/sumador_bk_pipe.sv
// Two-stage pipelined Brent-Kung prefix adder/subtractor with valid/ready handshake.
// Stage 1 runs the first SPLIT prefix levels; stage 2 finishes the tree and registers result and flags.
module sumador_bk_pipe #(
  parameter int WIDTH = 8,
  parameter int SPLIT = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             ovf,
  output logic             zero
);

  localparam int LOG    = $clog2(WIDTH);
  localparam int LEVELS = 2 * LOG - 1;

  generate
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("sumador_bk_pipe: WIDTH must be a power of two in 4..64");
    end
    if (SPLIT < 1 || SPLIT > LEVELS) begin : g_bad_split
      $error("sumador_bk_pipe: SPLIT must be in 1..2*log2(WIDTH)-1");
    end
  endgenerate

  // One Brent-Kung level: levels 0..LOG-1 are the up-sweep, the rest the down-sweep.
  function automatic logic [2*WIDTH-1:0] bk_level(input int lvl,
                                                  input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g_out;
    logic [WIDTH-1:0] p_out;
    logic             up;
    logic             hit;
    int               span;
    g_out = g_in;
    p_out = p_in;
    up    = (lvl < LOG);
    span  = up ? (1 << lvl) : (1 << (2 * LOG - 2 - lvl));
    for (int i = 0; i < WIDTH; i++) begin
      if (up) hit = ((i + 1) % (2 * span)) == 0;
      else    hit = (((i + 1) % (2 * span)) == span) && ((i + 1) >= 3 * span);
      if (hit && i >= span) begin
        g_out[i] = g_in[i] | (p_in[i] & g_in[i-span]);
        p_out[i] = p_in[i] & p_in[i-span];
      end
    end
    return {g_out, p_out};
  endfunction

  logic             vld_p1_q, vld_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic             s2_adv, ld_p1, ld_p2;
  logic [WIDTH-1:0] be;
  logic [WIDTH-1:0] p_p1_d, g_p1_d, pp_p1_d;
  logic [WIDTH-1:0] p_p1_q, g_p1_q, pp_p1_q;
  logic             amsb_p1_q, bmsb_p1_q, cin_p1_q;
  logic [WIDTH-1:0] g_s2, pp_s2, carry;
  logic [WIDTH-1:0] sum_p2_d, sum_p2_q;
  logic             c_p2_d, ovf_p2_d, zero_p2_d;
  logic             c_p2_q, ovf_p2_q, zero_p2_q;

  always_comb begin
    s2_adv   = ~vld_p2_q | out_ready;
    in_ready = ~vld_p1_q | s2_adv;
    ld_p1    = in_valid & in_ready;
    ld_p2    = s2_adv & vld_p1_q;
    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    vld_p2_d = s2_adv ? vld_p1_q : vld_p2_q;
  end

  // Stage 1: bit-level g/p, cin folded into bit 0 as a generate, first SPLIT levels.
  always_comb begin
    be      = sub ? ~b : b;
    p_p1_d  = a ^ be;
    g_p1_d  = a & be;
    g_p1_d[0] = g_p1_d[0] | (p_p1_d[0] & cin);
    pp_p1_d = p_p1_d;
    for (int lvl = 0; lvl < SPLIT; lvl++) begin
      {g_p1_d, pp_p1_d} = bk_level(lvl, g_p1_d, pp_p1_d);
    end
  end

  // Stage 2: remaining levels; group generates become carries C[1..WIDTH].
  always_comb begin
    g_s2  = g_p1_q;
    pp_s2 = pp_p1_q;
    for (int lvl = SPLIT; lvl < LEVELS; lvl++) begin
      {g_s2, pp_s2} = bk_level(lvl, g_s2, pp_s2);
    end
    carry     = {g_s2[WIDTH-2:0], cin_p1_q};
    sum_p2_d  = p_p1_q ^ carry;
    c_p2_d    = g_s2[WIDTH-1];
    ovf_p2_d  = ~(amsb_p1_q ^ bmsb_p1_q) & (sum_p2_d[WIDTH-1] ^ amsb_p1_q);
    zero_p2_d = ~|sum_p2_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      p_p1_q    <= '0;
      g_p1_q    <= '0;
      pp_p1_q   <= '0;
      amsb_p1_q <= 1'b0;
      bmsb_p1_q <= 1'b0;
      cin_p1_q  <= 1'b0;
      sum_p2_q  <= '0;
      c_p2_q    <= 1'b0;
      ovf_p2_q  <= 1'b0;
      zero_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (ld_p1) begin
        p_p1_q    <= p_p1_d;
        g_p1_q    <= g_p1_d;
        pp_p1_q   <= pp_p1_d;
        amsb_p1_q <= a[WIDTH-1];
        bmsb_p1_q <= be[WIDTH-1];
        cin_p1_q  <= cin;
      end
      if (ld_p2) begin
        sum_p2_q  <= sum_p2_d;
        c_p2_q    <= c_p2_d;
        ovf_p2_q  <= ovf_p2_d;
        zero_p2_q <= zero_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
  assign c         = c_p2_q;
  assign ovf       = ovf_p2_q;
  assign zero      = zero_p2_q;

endmodule

// File: doc/sumador_bk_pipe.md
Name: sumador_bk_pipe

Overview:
- Parametrised, pipelined Brent-Kung prefix adder/subtractor. It is the next generation of the 4-bit combinational Brent-Kung sumador.
- Generalised to WIDTH bits, with an add/subtract mode and overflow/zero flags.
- Fixed 2-stage pipeline with a valid/ready handshake and backpressure.
- Sits in the ALU datapath between the operand-select logic and the result writeback register.

Parameters:
- WIDTH, 8, operand width; must be a power of two, 4..64. Elaboration fails otherwise.
- SPLIT, log2(WIDTH), number of prefix levels computed in stage 1. Must be 1..2*log2(WIDTH)-1. Remaining levels are computed in stage 2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept an operand beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (drive 1 for plain A-B)
- sub  in  1  0: A+B+cin; 1: A+~B+cin
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result this cycle
- sum  out  WIDTH  result
- c  out  1  carry-out of MSB (for subtract: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset: while rst is high, and asynchronously on assertion:
  - s1_valid=0, out_valid=0.
  - sum=0, c=0, ovf=0, zero=0.
  - in_ready=1 after reset (combinational from empty state).
  - Data registers are cleared too, so no X appears on any output.
- Effective operand: be = sub ? ~b : b. Per bit, g[i]=a[i]&be[i] and p[i]=a[i]^be[i].
- Prefix tree: Brent-Kung.
  - cin is treated as generate at position -1.
  - Up-sweep of log2(WIDTH) levels, then down-sweep of log2(WIDTH)-1 levels, using gray/black cell semantics: (G,P)o(G',P') = (G|P&G', P&P').
  - Carries: C[0]=cin; C[i+1]=group generate of bits i..0 including cin.
  - sum[i]=p[i]^C[i]; c=C[WIDTH].
  - ovf=C[WIDTH]^C[WIDTH-1]; zero=~|sum.
- Pipeline:
  - Stage 1 register captures p, partial (G,P) after SPLIT prefix levels, a[MSB], be[MSB] and cin.
  - Stage 2 completes the tree and registers sum/c/ovf/zero.
  - Latency: exactly 2 cycles from an accepted input beat to out_valid, if unstalled.
  - Throughput: one beat per cycle.
- Handshake:
  - Input accepted on cycle where in_valid & in_ready.
  - Output consumed on cycle where out_valid & out_ready.
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = s2_adv (stage 1 moves into stage 2 when stage 2 empties or drains).
  - in_ready = ~s1_valid | s2_adv. This is a combinational path from out_ready; accepted.
- Stall:
  - When out_valid=1 and out_ready=0, sum/c/ovf/zero/out_valid hold bit-exact.
  - Stage 1 holds if occupied.
  - in_ready drops only when both stages are full and stalled.
- Simultaneous events: input accept and output consume in the same cycle with a full pipe shift everything by one stage. No bubble and no loss.
- Stage 2 with s1_valid=0 and s2_adv=1: out_valid goes 0 next cycle. Data regs may hold stale values.
- Operand changes while in_valid=1 and in_ready=0: ignored; only the accepted beat matters.
- Wrap-around: arithmetic is modulo 2^WIDTH.
  - All-ones + 1 gives sum=0, c=1, zero=1.
  - Subtract with a==b, cin=1 gives sum=0, c=1.
- Reset mid-operation: in-flight beats are discarded; no output beat appears after rst deasserts until new input is accepted.
- No combinational path from a/b/cin/sub to any output.

Test Plan (WIDTH=8, SPLIT=3 unless noted):
- Basic add: a=0x3C, b=0x15, cin=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x51, c=0, ovf=0, zero=0.
- Wrap/overflow: a=0xFF, b=0x01, cin=0 -> sum=0x00, c=1, zero=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, ovf=1, c=0.
- Subtract: a=0x10, b=0x20, sub=1, cin=1 -> sum=0xF0, c=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1, cin=1 -> sum=0x7F, ovf=1, c=1.
- Backpressure: stream 4 beats back-to-back with out_ready=0 -> after 2 accepts in_ready=0. Outputs hold the first result stable. Raise out_ready -> all 4 results appear in order, no drops or duplicates, 1 beat per cycle.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle mid-cycle (async) -> out_valid=0 and sum=0 immediately. No stale beat emerges after release. in_ready=1.
- Random/exhaustive: WIDTH=4 with SPLIT=1..3 exhaustive over a, b, cin, sub; WIDTH=32/64 random 10k beats with random out_ready -> every result matches the reference model (a + (sub?~b:b) + cin), with flags checked and order preserved.
